cache_tag_array: RTL and testbench

- Parametrised N-way set-associative tag store for the I/D caches. It replaces the single-way 256x20 tag table.
- Holds tag, valid and optional dirty bits per way, with one-cycle lookup, hit detection and victim selection.
- Self-clears after reset and on flush using a sequential init walk, because the backing sp_ram has no reset.
- Sits between the cache controller FSM and the per-way data arrays.

---
 rtl/cache_tag_array.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_tag_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_array.sv
//------------------------------------------------------------------------------
// cache_tag_array : N-way set-associative tag store with lookup, hit detect,
//                   victim selection and self-clearing init walk.
// Optional macro  : CACHE_DIRTY_EN (per-line dirty bit storage)
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_tag_array_sp_ram #(
    parameter int DATA_WIDTH = 21,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data only moves on a read, so a response stays stable until the next lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end
endmodule

module cache_tag_array #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 8,
    parameter int NUM_WAYS    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    output logic                   init_done_o,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [INDEX_WIDTH-1:0] lkp_index_i,
    input  logic [TAG_WIDTH-1:0]   lkp_tag_i,
    output logic                   rsp_valid_o,
    output logic                   hit_o,
    output logic [NUM_WAYS-1:0]    hit_way_o,
    output logic [NUM_WAYS-1:0]    victim_way_o,
    output logic [TAG_WIDTH-1:0]   victim_tag_o,
    output logic                   victim_valid_o,
    output logic                   victim_dirty_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [NUM_WAYS-1:0]    wr_way_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic                   wr_valid_i,
    input  logic                   wr_dirty_i
);
    localparam int WAY_AW   = $clog2(NUM_WAYS);
    localparam int NUM_SETS = 2**INDEX_WIDTH;
`ifdef CACHE_DIRTY_EN
    localparam int WORD_W   = TAG_WIDTH + 2;
`else
    localparam int WORD_W   = TAG_WIDTH + 1;
`endif
    localparam logic [NUM_WAYS-1:0] ONE_WAY = NUM_WAYS'(1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] init_cnt;
    logic                   in_idle;
    logic                   lkp_accept;

    logic [INDEX_WIDTH-1:0] ram_addr;
    logic [WORD_W-1:0]      ram_wdata;
    logic [NUM_WAYS-1:0]    ram_en;
    logic [NUM_WAYS-1:0]    ram_we;
    logic [WORD_W-1:0]      rd_word [NUM_WAYS];
    logic [TAG_WIDTH-1:0]   rd_tag  [NUM_WAYS];
    logic [NUM_WAYS-1:0]    rd_valid;
    logic [NUM_WAYS-1:0]    rd_dirty;

    logic [WAY_AW-1:0]      rr_ptr [NUM_SETS];
    logic [WAY_AW-1:0]      rr_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   rsp_q;
    logic                   have_rsp;

    logic [NUM_WAYS-1:0]    hit_vec;
    logic [WAY_AW-1:0]      vic_idx;
    logic                   vic_found;

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    assign in_idle     = (state == ST_IDLE);
    assign init_done_o = in_idle;
    assign lkp_ready_o = in_idle && !wr_en_i;
    assign lkp_accept  = lkp_valid_i && lkp_ready_o;

    // ---------------------------------------------------------------- RAM port
    always_comb begin
        ram_addr  = lkp_index_i;
        ram_wdata = '0;
        ram_en    = '0;
        ram_we    = '0;
        if (!in_idle) begin
            ram_addr = init_cnt;
            ram_en   = '1;
            ram_we   = '1;
        end else if (wr_en_i) begin
            ram_addr = wr_index_i;
`ifdef CACHE_DIRTY_EN
            ram_wdata = {wr_dirty_i, wr_valid_i, wr_tag_i};
`else
            ram_wdata = {wr_valid_i, wr_tag_i};
`endif
            ram_en   = wr_way_i;
            ram_we   = wr_way_i;
        end else if (lkp_accept) begin
            ram_en   = '1;
        end
    end

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            cache_tag_array_sp_ram #(
                .DATA_WIDTH (WORD_W),
                .ADDR_WIDTH (INDEX_WIDTH)
            ) u_ram (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (ram_en[w]),
                .we    (ram_we[w]),
                .addr  (ram_addr),
                .wdata (ram_wdata),
                .rdata (rd_word[w])
            );

            assign rd_tag[w]   = rd_word[w][TAG_WIDTH-1:0];
            assign rd_valid[w] = rd_word[w][TAG_WIDTH];
`ifdef CACHE_DIRTY_EN
            assign rd_dirty[w] = rd_word[w][TAG_WIDTH+1];
`else
            assign rd_dirty[w] = 1'b0;
`endif
        end
    endgenerate

    // ---------------------------------------------------------- RR pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (!in_idle) begin
            rr_ptr[init_cnt] <= '0;
        end else if (wr_en_i && wr_valid_i &&
                     (wr_way_i == (ONE_WAY << rr_ptr[wr_index_i]))) begin
            rr_ptr[wr_index_i] <= rr_ptr[wr_index_i] + 1'b1;
        end
    end

    // ------------------------------------------------------- lookup register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q    <= 1'b0;
            tag_q    <= '0;
            rr_q     <= '0;
            have_rsp <= 1'b0;
        end else begin
            rsp_q <= lkp_accept;
            if (lkp_accept) begin
                tag_q    <= lkp_tag_i;
                rr_q     <= rr_ptr[lkp_index_i];
                have_rsp <= 1'b1;
            end
        end
    end

    assign rsp_valid_o = rsp_q;

    // --------------------------------------------------- hit / victim select
    always_comb begin
        hit_vec   = '0;
        vic_idx   = rr_q;
        vic_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = rd_valid[w] && (rd_tag[w] == tag_q);
            if (!vic_found && !rd_valid[w]) begin
                vic_idx   = WAY_AW'(w);
                vic_found = 1'b1;
            end
        end
    end

    // Inputs to the result logic are all held, so gating by have_rsp keeps outputs stable.
    assign hit_way_o      = have_rsp ? hit_vec : '0;
    assign hit_o          = |hit_way_o;
    assign victim_way_o   = have_rsp ? (ONE_WAY << vic_idx) : '0;
    assign victim_tag_o   = have_rsp ? rd_tag[vic_idx] : '0;
    assign victim_valid_o = have_rsp && rd_valid[vic_idx];
`ifdef CACHE_DIRTY_EN
    assign victim_dirty_o = have_rsp && rd_dirty[vic_idx];
`else
    logic unused_dirty;
    assign unused_dirty   = wr_dirty_i ^ (|rd_dirty);
    assign victim_dirty_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_tag_array.sv
//------------------------------------------------------------------------------
// tb_cache_tag_array : directed scoreboard bench for cache_tag_array (2 ways).
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_tag_array;
    localparam int TW = 20;
    localparam int IW = 8;
    localparam int NW = 2;
`ifdef CACHE_DIRTY_EN
    localparam logic DIRTY_ON = 1'b1;
`else
    localparam logic DIRTY_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          init_done_o;
    logic          lkp_valid_i;
    logic          lkp_ready_o;
    logic [IW-1:0] lkp_index_i;
    logic [TW-1:0] lkp_tag_i;
    logic          rsp_valid_o;
    logic          hit_o;
    logic [NW-1:0] hit_way_o;
    logic [NW-1:0] victim_way_o;
    logic [TW-1:0] victim_tag_o;
    logic          victim_valid_o;
    logic          victim_dirty_o;
    logic          wr_en_i;
    logic [IW-1:0] wr_index_i;
    logic [NW-1:0] wr_way_i;
    logic [TW-1:0] wr_tag_i;
    logic          wr_valid_i;
    logic          wr_dirty_i;

    cache_tag_array #(
        .TAG_WIDTH   (TW),
        .INDEX_WIDTH (IW),
        .NUM_WAYS    (NW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .init_done_o    (init_done_o),
        .lkp_valid_i    (lkp_valid_i),
        .lkp_ready_o    (lkp_ready_o),
        .lkp_index_i    (lkp_index_i),
        .lkp_tag_i      (lkp_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .victim_way_o   (victim_way_o),
        .victim_tag_o   (victim_tag_o),
        .victim_valid_o (victim_valid_o),
        .victim_dirty_o (victim_dirty_o),
        .wr_en_i        (wr_en_i),
        .wr_index_i     (wr_index_i),
        .wr_way_i       (wr_way_i),
        .wr_tag_i       (wr_tag_i),
        .wr_valid_i     (wr_valid_i),
        .wr_dirty_i     (wr_dirty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [NW-1:0] hw;
        logic [NW-1:0] vw;
        logic [TW-1:0] vt;
        logic          vv;
        logic          vd;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycles;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("hit", 32'(hit_o), 32'(e.hit));
            check("hit_way", 32'(hit_way_o), 32'(e.hw));
            check("victim_way", 32'(victim_way_o), 32'(e.vw));
            check("victim_tag", 32'(victim_tag_o), 32'(e.vt));
            check("victim_valid", 32'(victim_valid_o), 32'(e.vv));
            check("victim_dirty", 32'(victim_dirty_o), 32'(e.vd));
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic do_write(input logic [IW-1:0] idx, input logic [NW-1:0] way,
                            input logic [TW-1:0] tag, input logic v, input logic d);
        wr_en_i    = 1'b1;
        wr_index_i = idx;
        wr_way_i   = way;
        wr_tag_i   = tag;
        wr_valid_i = v;
        wr_dirty_i = d;
        @(negedge clk);
        wr_en_i    = 1'b0;
    endtask

    task automatic do_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                             input logic hit, input logic [NW-1:0] hw, input logic [NW-1:0] vw,
                             input logic [TW-1:0] vt, input logic vv, input logic vd);
        sb.push_back('{hit: hit, hw: hw, vw: vw, vt: vt, vv: vv, vd: vd});
        lkp_valid_i = 1'b1;
        lkp_index_i = idx;
        lkp_tag_i   = tag;
        #1;
        check("lkp_ready", 32'(lkp_ready_o), 32'd1);
        @(negedge clk);
        lkp_valid_i = 1'b0;
        check_rsp();
    endtask

    // Counts rising edges until init_done, optionally pulsing flush mid-walk.
    task automatic wait_init(output int n, input int flush_at);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            flush_i = (n == flush_at);
            if (init_done_o) break;
            check("ready_in_init", 32'(lkp_ready_o), 32'd0);
        end
        flush_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        lkp_valid_i = 1'b0;
        lkp_index_i = '0;
        lkp_tag_i   = '0;
        wr_en_i     = 1'b0;
        wr_index_i  = '0;
        wr_way_i    = '0;
        wr_tag_i    = '0;
        wr_valid_i  = 1'b0;
        wr_dirty_i  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_lkp_ready", 32'(lkp_ready_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_hit", 32'(hit_o), 32'd0);
        check("rst_hit_way", 32'(hit_way_o), 32'd0);
        check("rst_victim_way", 32'(victim_way_o), 32'd0);
        check("rst_victim_tag", 32'(victim_tag_o), 32'd0);
        check("rst_victim_valid", 32'(victim_valid_o), 32'd0);
        check("rst_victim_dirty", 32'(victim_dirty_o), 32'd0);

        rst_n = 1'b1;
        wait_init(cycles, -1);
        check("init_cycles", 32'(cycles), 32'd256);

        // Empty set after init
        do_lookup(8'h12, 20'hABCDE, 1'b0, 2'b00, 2'b01, 20'h0, 1'b0, 1'b0);
        do_lookup(8'hFF, 20'h00000, 1'b0, 2'b00, 2'b01, 20'h0, 1'b0, 1'b0);

        do_write(8'h12, 2'b01, 20'hABCDE, 1'b1, 1'b1);
        do_lookup(8'h12, 20'hABCDE, 1'b1, 2'b01, 2'b10, 20'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("hold_hit", 32'(hit_o), 32'd1);
        check("hold_victim_way", 32'(victim_way_o), 32'b10);

        // Fill second way, then round-robin refills
        do_write(8'h12, 2'b10, 20'h11111, 1'b1, 1'b0);
        do_lookup(8'h12, 20'h11111, 1'b1, 2'b10, 2'b01, 20'hABCDE, 1'b1, DIRTY_ON);
        do_write(8'h12, 2'b01, 20'h22222, 1'b1, 1'b0);
        do_lookup(8'h12, 20'hABCDE, 1'b0, 2'b00, 2'b10, 20'h11111, 1'b1, 1'b0);
        do_write(8'h12, 2'b10, 20'h33333, 1'b1, 1'b1);
        do_lookup(8'h12, 20'h33333, 1'b1, 2'b10, 2'b01, 20'h22222, 1'b1, 1'b0);
        do_write(8'h12, 2'b01, 20'h44444, 1'b1, 1'b0);
        do_lookup(8'h12, 20'h44444, 1'b1, 2'b01, 2'b10, 20'h33333, 1'b1, DIRTY_ON);

        // Write and lookup in the same cycle: write wins
        wr_en_i     = 1'b1;
        wr_index_i  = 8'h34;
        wr_way_i    = 2'b01;
        wr_tag_i    = 20'h55555;
        wr_valid_i  = 1'b1;
        wr_dirty_i  = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_index_i = 8'h34;
        lkp_tag_i   = 20'h55555;
        #1;
        check("collide_ready", 32'(lkp_ready_o), 32'd0);
        @(negedge clk);
        wr_en_i     = 1'b0;
        lkp_valid_i = 1'b0;
        check("collide_no_rsp", 32'(rsp_valid_o), 32'd0);
        do_lookup(8'h34, 20'h55555, 1'b1, 2'b01, 2'b10, 20'h0, 1'b0, 1'b0);

        // Dirty lines then flush
        do_write(8'h56, 2'b01, 20'h66666, 1'b1, 1'b1);
        do_write(8'h56, 2'b10, 20'h77777, 1'b1, 1'b1);
        do_lookup(8'h56, 20'h66666, 1'b1, 2'b01, 2'b01, 20'h66666, 1'b1, DIRTY_ON);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_init_done", 32'(init_done_o), 32'd0);
        wait_init(cycles, 10);
        check("flush_cycles", 32'(cycles), 32'd256);
        do_lookup(8'h56, 20'h66666, 1'b0, 2'b00, 2'b01, 20'h0, 1'b0, 1'b0);
        do_lookup(8'h12, 20'h44444, 1'b0, 2'b00, 2'b01, 20'h0, 1'b0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
